// File: rtl/md_div_sequencer.sv
// md_div_sequencer
//   Multi-cycle radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU
//   instructions. It sits beside the combinational M-extension ALU. It holds
//   the single-cycle core by gating the PC write enable until the result is
//   ready. It then presents the result together with a one-cycle write
//   qualifier.
//
// Ports
//   CPU_clk      core clock, rising edge
//   CPU_rst_n    asynchronous active-low reset
//   start        divide-class instruction present (level, held while stalled)
//   op           00 DIV, 01 DIVU, 10 REM, 11 REMU
//   Op1, Op2     dividend, divisor
//   CPU_PCWrite  global PC enable from the core top
//   PCWrite_out  gated PC enable toward the program counter
//   busy         high while iterating
//   wb_en        result-valid / register write qualifier
//   result       quotient or remainder, stable from DONE until replaced
module md_div_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int FAST_SPECIAL = 1
) (
  input  logic                  CPU_clk,
  input  logic                  CPU_rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] Op1,
  input  logic [DATA_WIDTH-1:0] Op2,
  input  logic                  CPU_PCWrite,
  output logic                  PCWrite_out,
  output logic                  busy,
  output logic                  wb_en,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  dvd_q, dvd_d;      // remaining dividend bits, MSB first
  logic [W-1:0]  dvs_q, dvs_d;      // divisor magnitude
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  rem_q, rem_d;
  logic          is_rem_q, is_rem_d;
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic [W-1:0]  result_q, result_d;

  // ---------------------------------------------------------------------
  // Operand conditioning (only meaningful in IDLE when start is sampled)
  // ---------------------------------------------------------------------
  logic         is_signed, op1_neg, op2_neg, div_zero, overflow, special;
  logic [W-1:0] op1_abs, op2_abs, special_res;

  always_comb begin
    is_signed = ~op[0];
    op1_neg   = is_signed & Op1[W-1];
    op2_neg   = is_signed & Op2[W-1];
    // Negating the most-negative value wraps to itself, which is already
    // its correct unsigned magnitude.
    op1_abs   = op1_neg ? (~Op1 + 1'b1) : Op1;
    op2_abs   = op2_neg ? (~Op2 + 1'b1) : Op2;
    div_zero  = (Op2 == '0);
    overflow  = is_signed & (Op1 == MOST_NEG) & (&Op2);
    special   = div_zero | overflow;
    if (div_zero) begin
      special_res = op[1] ? Op1 : '1;
    end else begin
      // signed overflow: quotient is the dividend itself, remainder is 0
      special_res = op[1] ? '0 : Op1;
    end
  end

  // ---------------------------------------------------------------------
  // One restoring step
  // ---------------------------------------------------------------------
  logic [W:0]   shifted, diff;
  logic         qbit;
  logic [W-1:0] rem_step, quot_step, quot_fix, rem_fix, final_res;

  always_comb begin
    shifted   = {rem_q, dvd_q[W-1]};
    // The partial remainder is always below the divisor. So a set MSB of
    // this (W+1)-bit difference means the trial subtraction went negative.
    diff      = shifted - {1'b0, dvs_q};
    qbit      = ~diff[W];
    rem_step  = qbit ? diff[W-1:0] : shifted[W-1:0];
    quot_step = {quot_q[W-2:0], qbit};
    quot_fix  = qneg_q ? (~quot_step + 1'b1) : quot_step;
    rem_fix   = rneg_q ? (~rem_step + 1'b1) : rem_step;
    final_res = is_rem_q ? rem_fix : quot_fix;
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    is_rem_d = is_rem_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_rem_d = op[1];
          dvd_d    = op1_abs;
          dvs_d    = op2_abs;
          quot_d   = '0;
          rem_d    = '0;
          // On the slow path a zero divisor yields an all-ones magnitude.
          // That quotient must stay -1, so the sign flip is suppressed.
          qneg_d   = (op1_neg ^ op2_neg) & ~div_zero;
          rneg_d   = op1_neg;
          cnt_d    = CNT_LAST;
          if ((FAST_SPECIAL != 0) && special) begin
            result_d = special_res;
            state_d  = S_DONE;
          end else begin
            state_d  = S_RUN;
          end
        end
      end

      S_RUN: begin
        dvd_d  = dvd_q << 1;
        rem_d  = rem_step;
        quot_d = quot_step;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          result_d = final_res;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        if (CPU_PCWrite) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge CPU_clk or negedge CPU_rst_n) begin
    if (!CPU_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      is_rem_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      is_rem_q <= is_rem_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  // The PC is held during the accepting IDLE cycle and throughout RUN. It is
  // released in DONE so the PC advances in the same cycle as write-back.
  assign PCWrite_out = CPU_PCWrite &
                       ~(((state_q == S_IDLE) & start) | (state_q == S_RUN));
  assign busy        = (state_q == S_RUN);
  assign wb_en       = (state_q == S_DONE) & CPU_PCWrite;
  assign result      = result_q;

endmodule

// File: tb/tb_md_div_sequencer.sv
// Directed bench for md_div_sequencer. A fast-special instance and a
// full-iteration instance share operand, op and PC-enable inputs. Each
// instance has its own start.
module tb_md_div_sequencer;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_f = 1'b0, start_s = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] op1 = '0, op2 = '0;
  logic        pcw = 1'b1;

  logic        pcw_out_f, busy_f, wb_f;
  logic [31:0] res_f;
  logic        pcw_out_s, busy_s, wb_s;
  logic [31:0] res_s;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  md_div_sequencer #(.DATA_WIDTH(32), .FAST_SPECIAL(1)) dut_fast (
    .CPU_clk(clk), .CPU_rst_n(rst_n), .start(start_f), .op(op),
    .Op1(op1), .Op2(op2), .CPU_PCWrite(pcw),
    .PCWrite_out(pcw_out_f), .busy(busy_f), .wb_en(wb_f), .result(res_f)
  );

  md_div_sequencer #(.DATA_WIDTH(32), .FAST_SPECIAL(0)) dut_slow (
    .CPU_clk(clk), .CPU_rst_n(rst_n), .start(start_s), .op(op),
    .Op1(op1), .Op2(op2), .CPU_PCWrite(pcw),
    .PCWrite_out(pcw_out_s), .busy(busy_s), .wb_en(wb_s), .result(res_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic sel_pcw(input bit slow);
    return slow ? pcw_out_s : pcw_out_f;
  endfunction
  function automatic logic sel_busy(input bit slow);
    return slow ? busy_s : busy_f;
  endfunction
  function automatic logic sel_wb(input bit slow);
    return slow ? wb_s : wb_f;
  endfunction
  function automatic logic [31:0] sel_res(input bit slow);
    return slow ? res_s : res_f;
  endfunction

  // Raise start on one instance in an IDLE cycle (cycle T). Wait for wb_en,
  // then check latency, result and stall gating. Start stays high through
  // DONE, like the stalled instruction would hold it.
  task automatic run_div(input bit slow, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat,
                         input string tag);
    int  n;
    bit  seen;
    @(negedge clk);
    op = o; op1 = a; op2 = b;
    start_f = ~slow; start_s = slow;
    #1;
    check_eq({tag, ":stall_T"}, 32'(sel_pcw(slow)), 32'd0);
    n = 0;
    seen = 0;
    while (!seen && n < 60) begin
      @(negedge clk);
      #1;
      n++;
      if (n == 1 && lat > 1) begin
        check_eq({tag, ":busy_T1"}, 32'(sel_busy(slow)), 32'd1);
        check_eq({tag, ":stall_T1"}, 32'(sel_pcw(slow)), 32'd0);
        // operand changes during RUN must be ignored
        op1 = ~a; op2 = a; op = ~o;
      end
      if (sel_wb(slow)) seen = 1;
    end
    if (!seen) begin
      check_eq({tag, ":timeout"}, 32'd0, 32'd1);
    end else begin
      check_eq({tag, ":latency"}, 32'(n), 32'(lat));
      check_eq({tag, ":result"}, sel_res(slow), exp);
      check_eq({tag, ":pcw_done"}, 32'(sel_pcw(slow)), 32'd1);
      check_eq({tag, ":busy_done"}, 32'(sel_busy(slow)), 32'd0);
    end
    $display("%s op=%0d a=%h b=%h result=%h cycles=%0d", tag, o, a, b,
             sel_res(slow), n);
  endtask

  initial begin
    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst:result", res_f, 32'd0);
    check_eq("rst:busy", 32'(busy_f), 32'd0);
    check_eq("rst:wb_en", 32'(wb_f), 32'd0);
    check_eq("rst:pcw_out", 32'(pcw_out_f), 32'd1);
    rst_n = 1'b1;

    // ---------------- normal path, back to back ----------------
    run_div(0, DIVU, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
    run_div(0, REMU, 32'd100, 32'd7, 32'd2, 33, "remu_100_7");
    run_div(0, DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2");
    run_div(0, REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2");
    run_div(0, REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, "rem_7_m2");
    run_div(0, DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, "divu_max_1");

    // ---------------- special cases, fast path ----------------
    run_div(0, DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "f_divu_5_0");
    run_div(0, REMU, 32'd5, 32'd0, 32'd5, 1, "f_remu_5_0");
    run_div(0, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "f_div_ovf");
    run_div(0, REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "f_rem_ovf");
    run_div(0, DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1, "f_div_m5_0");

    // ---------------- special cases, full iteration ----------------
    run_div(1, DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 33, "s_divu_5_0");
    run_div(1, REMU, 32'd5, 32'd0, 32'd5, 33, "s_remu_5_0");
    run_div(1, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, "s_div_ovf");
    run_div(1, REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, "s_rem_ovf");
    run_div(1, DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 33, "s_div_m5_0");
    run_div(1, REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 33, "s_rem_m5_0");

    // start held through DONE must not have restarted anything
    @(negedge clk);
    start_f = 0; start_s = 0;
    #1;
    check_eq("idle:busy_s", 32'(busy_s), 32'd0);
    check_eq("idle:wb_s", 32'(wb_s), 32'd0);
    check_eq("idle:busy_f", 32'(busy_f), 32'd0);

    // ---------------- reset mid-operation ----------------
    @(negedge clk);
    op = DIVU; op1 = 32'd1000; op2 = 32'd3; start_f = 1;
    repeat (10) @(negedge clk);
    rst_n = 0; start_f = 0;
    #1;
    check_eq("rst_mid:busy", 32'(busy_f), 32'd0);
    check_eq("rst_mid:wb_en", 32'(wb_f), 32'd0);
    check_eq("rst_mid:result", res_f, 32'd0);
    check_eq("rst_mid:pcw_out", 32'(pcw_out_f), 32'(pcw));
    check_eq("rst_mid:result_s", res_s, 32'd0);
    @(negedge clk);
    rst_n = 1;
    run_div(0, DIVU, 32'd9, 32'd3, 32'd3, 33, "divu_9_3");

    // ---------------- CPU_PCWrite held low in DONE ----------------
    @(negedge clk);
    op = DIVU; op1 = 32'd1000; op2 = 32'd10; start_f = 1; start_s = 0; pcw = 0;
    repeat (33) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check_eq($sformatf("hold%0d:wb_en", k), 32'(wb_f), 32'd0);
      check_eq($sformatf("hold%0d:result", k), res_f, 32'd100);
      check_eq($sformatf("hold%0d:busy", k), 32'(busy_f), 32'd0);
    end
    @(negedge clk);
    pcw = 1;
    #1;
    check_eq("hold:wb_pulse", 32'(wb_f), 32'd1);
    check_eq("hold:pcw_out", 32'(pcw_out_f), 32'd1);
    check_eq("hold:result", res_f, 32'd100);
    $display("hold_divu_1000_10 released result=%h", res_f);
    @(negedge clk);
    start_f = 0;
    #1;
    check_eq("hold:wb_single", 32'(wb_f), 32'd0);
    check_eq("hold:idle_busy", 32'(busy_f), 32'd0);
    run_div(0, DIVU, 32'd8, 32'd2, 32'd4, 33, "divu_8_2");

    @(negedge clk);
    start_f = 0; start_s = 0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/md_div_sequencer.md
Name: md_div_sequencer

Overview:
- Multi-cycle sequencer for the RV32M divide/remainder operations (DIV, DIVU, REM, REMU).
- Executes a radix-2 restoring division over DATA_WIDTH cycles.
- Stalls the single-cycle core by gating the program-counter write enable until the result is ready.
- Sits beside the combinational M-extension ALU, which keeps MUL*. Its result feeds the ALU result select toward the register-file write port.

Parameters:
- DATA_WIDTH, 32: operand/result width; iteration count equals DATA_WIDTH.
- FAST_SPECIAL, 1: 1 = divide-by-zero and signed-overflow complete in 1 cycle; 0 = they run the full iteration with the same final values.

Ports:
- CPU_clk  input  1  core clock, rising edge.
- CPU_rst_n  input  1  asynchronous active-low reset.
- start  input  1  divide-class instruction present (MDSel & div/rem ALUControl); level, held by the stalled instruction.
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- Op1  input  DATA_WIDTH  dividend.
- Op2  input  DATA_WIDTH  divisor.
- CPU_PCWrite  input  1  global PC enable from the core top.
- PCWrite_out  output  1  gated PC enable to the program counter.
- busy  output  1  high in RUN state.
- wb_en  output  1  one-cycle result-valid / register write qualifier.
- result  output  DATA_WIDTH  quotient or remainder.

Behaviour:
- Reset (async, CPU_rst_n=0):
  - state=IDLE; counter, operand, quotient and remainder registers = 0.
  - result=0, busy=0, wb_en=0.
  - Reset mid-operation aborts immediately; nothing is written back.
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - Capture op, |Op1|, |Op2| (absolute value only for DIV/REM).
  - Capture quotient sign = Op1[MSB]^Op2[MSB] and remainder sign = Op1[MSB] (signed ops only).
  - Load counter = DATA_WIDTH-1.
  - Next state RUN, or DONE when FAST_SPECIAL=1 and a special case applies.
- RUN, one quotient bit per cycle:
  - Shift partial remainder left by one, bringing in the next dividend MSB.
  - Trial-subtract the divisor with a (DATA_WIDTH+1)-bit subtract.
  - If non-negative, keep the difference and set the quotient bit to 1; else set it to 0.
  - At counter=0, apply sign fix-up (two's-complement negate per captured signs), register the result, go to DONE.
  - Op1/Op2/op/start changes during RUN are ignored.
- DONE:
  - wb_en = CPU_PCWrite.
  - Go to IDLE when CPU_PCWrite=1; otherwise hold DONE with result stable.
- Stall gating (combinational):
  - PCWrite_out = CPU_PCWrite & ~((state==IDLE & start) | state==RUN).
  - PCWrite_out is high in DONE, so the PC advances in the same cycle the result is written.
- start is sampled only in IDLE. The still-present start in the DONE cycle never restarts the operation.
- Latency:
  - Start accepted at edge T.
  - Normal path: RUN spans T+1..T+DATA_WIDTH; DONE/wb_en at cycle T+DATA_WIDTH+1 (33 for 32-bit).
  - Special path: DONE at T+1.
- Special results, per RISC-V:
  - Divisor 0: DIV/DIVU = all ones; REM/REMU = Op1.
  - DIV of most-negative by -1 = most-negative; REM of the same = 0.
  - Unsigned ops never overflow.
- result holds its value from DONE until the next accepted start. busy is 0 outside RUN.
- Back-to-back divides: a new start is accepted in the IDLE cycle directly following DONE.

Test Plan:
- DIVU Op1=100, Op2=7, start at T:
  - PCWrite_out low T..T+32; busy high T+1..T+32.
  - wb_en and PCWrite_out high at T+33 with result=14.
  - REMU on the same operands gives 2.
- Signed DIV Op1=-7 (0xFFFFFFF9), Op2=2: result 0xFFFFFFFD.
  - REM on the same operands gives 0xFFFFFFFF.
  - REM Op1=7, Op2=-2 gives 1.
- Divide-by-zero, FAST_SPECIAL=1: DIVU 5/0 gives wb_en at T+1, result 0xFFFFFFFF; REMU 5/0 gives 5.
  - Rerun with FAST_SPECIAL=0: same values at T+33.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM on the same gives 0; both at T+1.
- Reset asserted at T+10 of a DIVU:
  - Immediately busy=0, wb_en=0, result=0, PCWrite_out=CPU_PCWrite.
  - After release, DIVU 9/3 completes at 33 cycles with result 3.
- CPU_PCWrite held low in DONE for 5 cycles:
  - State stays DONE, wb_en=0, result stable.
  - On CPU_PCWrite=1, exactly one wb_en pulse, then IDLE.
  - A following start with DIVU 8/2 yields 4.
